data_memory_responder: RTL

//  Memory-side responder for the LSU memory interface (enable/state/address/frame_mask/inout data).

---
 rtl/data_memory_responder_if.sv | 41 ++++
 rtl/data_memory_responder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/data_memory_responder_if.sv
// Request/handshake bundle between the LSU and data_memory_responder.
// Build macro: MEMORY_ACCESS_FAULT_EN adds the fault signal.
`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

interface data_memory_responder_if;
    logic        enable;
    logic        state;
    logic [31:0] address;
    logic [3:0]  frame_mask;
    logic        ready;
`ifdef MEMORY_ACCESS_FAULT_EN
    logic        fault;
`endif

    modport master (
        output enable,
        output state,
        output address,
        output frame_mask,
`ifdef MEMORY_ACCESS_FAULT_EN
        input  fault,
`endif
        input  ready
    );

    modport slave (
        input  enable,
        input  state,
        input  address,
        input  frame_mask,
`ifdef MEMORY_ACCESS_FAULT_EN
        output fault,
`endif
        output ready
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-organised SRAM responder for the LSU bus: one request at a time, programmable wait states.
// Build macro: MEMORY_ACCESS_FAULT_EN enables out-of-range detection and the fault pulse.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    data_memory_responder_if.slave memory_interface,
    inout  wire  [31:0]            memory_interface_data
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((WAIT_STATES == 0) ? 0 : (WAIT_STATES - 1));

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, commit;
    logic             wr_q, rd_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       lane_q;
    logic [31:0]      wdata_q;
    logic             ready_q, drive_q;
    logic [31:0]      rdata_q;

    // Request decode; lanes reordered so lane b covers data[8b+7:8b]
    logic [31:0]      offset;
    logic [IDX_W-1:0] req_idx, cur_idx;
    logic             req_wr, req_rd, cur_rd, cur_oor;
    logic [3:0]       req_lane;

    assign offset   = memory_interface.address - BASE_ADDRESS;
    assign req_idx  = IDX_W'(offset >> 2);
    assign req_wr   = (memory_interface.state === `WRITE);
    assign req_rd   = (memory_interface.state === `READ);
    assign req_lane = {memory_interface.frame_mask[0] === 1'b1,
                       memory_interface.frame_mask[1] === 1'b1,
                       memory_interface.frame_mask[2] === 1'b1,
                       memory_interface.frame_mask[3] === 1'b1};

`ifdef MEMORY_ACCESS_FAULT_EN
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
    logic req_oor, oor_q, fault_q;
    assign req_oor = (offset >= SPAN);
    assign cur_oor = accept ? req_oor : oor_q;
    assign memory_interface.fault = fault_q;
`else
    assign cur_oor = 1'b0;
`endif

    // With zero wait states the read is registered in the accepting cycle
    assign cur_idx = accept ? req_idx : idx_q;
    assign cur_rd  = accept ? req_rd  : rd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memory_interface.enable) begin
                    accept  = 1'b1;
                    state_d = (WAIT_STATES == 0) ? ST_RESPOND : ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (!memory_interface.enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
                commit  = wr_q && !cur_oor && !reset;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            drive_q <= 1'b0;
            rdata_q <= '0;
`ifdef MEMORY_ACCESS_FAULT_EN
            oor_q   <= 1'b0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_wr;
                rd_q    <= req_rd;
                idx_q   <= req_idx;
                lane_q  <= req_lane;
                wdata_q <= memory_interface_data;
`ifdef MEMORY_ACCESS_FAULT_EN
                oor_q   <= req_oor;
`endif
            end
            ready_q <= (state_d == ST_RESPOND);
            drive_q <= (state_d == ST_RESPOND) && cur_rd;
            if (state_d == ST_RESPOND) begin
                rdata_q <= cur_oor ? 32'h0000_0000 : mem[cur_idx];
            end
`ifdef MEMORY_ACCESS_FAULT_EN
            fault_q <= (state_d == ST_RESPOND) && cur_oor;
`endif
        end
    end

    // Array is never reset; byte-lane write at the end of RESPOND
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign memory_interface.ready = ready_q;
    assign memory_interface_data  = drive_q ? rdata_q : 32'bz;
endmodule
